// File: rtl/dp_ctrl_if.sv
// Control bundle between the integer datapath and its multi-cycle sequencer.
// The sequencer (master) drives the enables and selects and consumes the decode
// fields, run and the EX-stage done flag.
// Handshake: mulstart is a one-cycle request pulse to the multiply unit;
// exdone is the unit's valid and is accepted only from the cycle after mulstart.
interface dp_ctrl_if #(
    parameter int pcmux_N     = 2,
    parameter int ifuresctl_N = 2
);
    logic                           run;
    logic [6:0]                     opcode;
    logic [2:0]                     func3;
    logic [1:0]                     func7b50;
    logic                           exdone;
    logic [$clog2(pcmux_N)-1:0]     pcmuxctl;
    logic                           pcnextctl;
    logic                           instrre;
    logic                           regwe;
    logic                           regre;
    logic [3:0]                     aluctl;
    logic                           mulstart;
    logic [1:0]                     mulctl;
    logic [$clog2(ifuresctl_N)-1:0] ifuresctl;
    logic                           busy;
    logic                           trap;
    logic [1:0]                     trap_cause;
    logic [31:0]                    instret;

    modport master (
        input  run, opcode, func3, func7b50, exdone,
        output pcmuxctl, pcnextctl, instrre, regwe, regre, aluctl, mulstart,
               mulctl, ifuresctl, busy, trap, trap_cause, instret
    );

    modport slave (
        output run, opcode, func3, func7b50, exdone,
        input  pcmuxctl, pcnextctl, instrre, regwe, regre, aluctl, mulstart,
               mulctl, ifuresctl, busy, trap, trap_cause, instret
    );
endinterface

// File: rtl/dp_ctrl.sv
// Multi-cycle sequencer for the integer datapath: FETCH, DECODE, EXEC, WB.
// Decodes R-type RV32I and M-extension multiplies, handshakes with the multiply
// unit and traps on illegal instructions or a multiply-unit timeout.
// All outputs are registered; the next-cycle value of each is computed alongside
// the next state so every output lines up with the state it belongs to.
module dp_ctrl #(
    parameter int pcmux_N     = 2,
    parameter int ifuresctl_N = 2,
    parameter int mu_timeout  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    dp_ctrl_if.master   bus,
    output logic [2:0]  dbg_state
);
    localparam int IW = $clog2(ifuresctl_N);
    localparam int CW = $clog2(mu_timeout + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic            instrre_q, instrre_d;
    logic            regre_q, regre_d;
    logic            regwe_q, regwe_d;
    logic            pcnext_q, pcnext_d;
    logic            mulstart_q, mulstart_d;
    logic [3:0]      aluctl_q, aluctl_d;
    logic [1:0]      mulctl_q, mulctl_d;
    logic [IW-1:0]   ifures_q, ifures_d;
    logic            is_mu_q, is_mu_d;
    logic            busy_q, busy_d;
    logic            trap_q, trap_d;
    logic [1:0]      cause_q, cause_d;
    logic [31:0]     instret_q, instret_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

    logic            dec_legal;
    logic            dec_mu;
    logic [3:0]      dec_alu;

    // Instruction decode of the fields presented during DECODE.
    always_comb begin
        dec_legal = 1'b0;
        dec_mu    = 1'b0;
        dec_alu   = 4'b0000;
        if (bus.opcode == 7'b0110011) begin
            case (bus.func7b50)
                2'b00: begin
                    dec_legal = 1'b1;
                    case (bus.func3)
                        3'b000:  dec_alu = 4'b0000;
                        3'b001:  dec_alu = 4'b0010;
                        3'b010:  dec_alu = 4'b0011;
                        3'b011:  dec_alu = 4'b0100;
                        3'b100:  dec_alu = 4'b0101;
                        3'b101:  dec_alu = 4'b0110;
                        3'b110:  dec_alu = 4'b1000;
                        default: dec_alu = 4'b1001;
                    endcase
                end
                2'b10: begin
                    if (bus.func3 == 3'b000) begin
                        dec_legal = 1'b1;
                        dec_alu   = 4'b0001;
                    end else if (bus.func3 == 3'b101) begin
                        dec_legal = 1'b1;
                        dec_alu   = 4'b0111;
                    end
                end
                2'b01: begin
                    if (!bus.func3[2]) begin
                        dec_legal = 1'b1;
                        dec_mu    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d    = state_q;
        instrre_d  = 1'b0;
        regre_d    = 1'b0;
        regwe_d    = 1'b0;
        pcnext_d   = 1'b0;
        mulstart_d = 1'b0;
        aluctl_d   = aluctl_q;
        mulctl_d   = mulctl_q;
        ifures_d   = ifures_q;
        is_mu_d    = is_mu_q;
        trap_d     = trap_q;
        cause_d    = cause_q;
        instret_d  = instret_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d   = S_FETCH;
                    instrre_d = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
                regre_d = 1'b1;
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b01;
                end else begin
                    state_d    = S_EXEC;
                    aluctl_d   = dec_alu;
                    is_mu_d    = dec_mu;
                    mulctl_d   = dec_mu ? bus.func3[1:0] : 2'b00;
                    ifures_d   = dec_mu ? IW'(1) : IW'(0);
                    mulstart_d = dec_mu;
                    wait_cnt_d = CW'(1);
                end
            end
            S_EXEC: begin
                if (!is_mu_q) begin
                    state_d   = S_WB;
                    regwe_d   = 1'b1;
                    pcnext_d  = 1'b1;
                    instret_d = instret_q + 32'd1;
                end else if (bus.exdone && wait_cnt_q != CW'(1)) begin
                    // First EXEC cycle is the mulstart cycle: a done seen there is stale.
                    state_d   = S_WB;
                    regwe_d   = 1'b1;
                    pcnext_d  = 1'b1;
                    instret_d = instret_q + 32'd1;
                end else if (wait_cnt_q >= CW'(mu_timeout)) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            S_WB: begin
                if (bus.run) begin
                    state_d   = S_FETCH;
                    instrre_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_TRAP);
    end

    // State and output registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            instrre_q  <= 1'b0;
            regre_q    <= 1'b0;
            regwe_q    <= 1'b0;
            pcnext_q   <= 1'b0;
            mulstart_q <= 1'b0;
            aluctl_q   <= 4'b0000;
            mulctl_q   <= 2'b00;
            ifures_q   <= '0;
            is_mu_q    <= 1'b0;
            busy_q     <= 1'b0;
            trap_q     <= 1'b0;
            cause_q    <= 2'b00;
            instret_q  <= 32'd0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            instrre_q  <= instrre_d;
            regre_q    <= regre_d;
            regwe_q    <= regwe_d;
            pcnext_q   <= pcnext_d;
            mulstart_q <= mulstart_d;
            aluctl_q   <= aluctl_d;
            mulctl_q   <= mulctl_d;
            ifures_q   <= ifures_d;
            is_mu_q    <= is_mu_d;
            busy_q     <= busy_d;
            trap_q     <= trap_d;
            cause_q    <= cause_d;
            instret_q  <= instret_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.pcmuxctl   = '0;
    assign bus.pcnextctl  = pcnext_q;
    assign bus.instrre    = instrre_q;
    assign bus.regwe      = regwe_q;
    assign bus.regre      = regre_q;
    assign bus.aluctl     = aluctl_q;
    assign bus.mulstart   = mulstart_q;
    assign bus.mulctl     = mulctl_q;
    assign bus.ifuresctl  = ifures_q;
    assign bus.busy       = busy_q;
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;
    assign bus.instret    = instret_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_dp_ctrl.sv
// Bench for dp_ctrl: drives instruction fields and the multiply-unit done flag,
// and scores each writeback against an expected record queued at issue time.
module tb_dp_ctrl;
    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;

    dp_ctrl_if #(.pcmux_N(2), .ifuresctl_N(2)) bus ();

    dp_ctrl #(.pcmux_N(2), .ifuresctl_N(2), .mu_timeout(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Expected writeback record: {latency[7:0], aluctl[3:0], mulctl[1:0], ifuresctl}
    logic [14:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int fetch_cyc = 0;
    int mulstart_cnt = 0;
    int viol_cnt = 0;
    int n_ret    = 0;

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor: scoreboard pop on every writeback, exclusivity tracking.
    always @(negedge clk) begin
        logic [14:0] e;
        cyc++;
        if (bus.instrre) fetch_cyc = cyc;
        if (bus.mulstart) mulstart_cnt++;
        if ((int'(bus.instrre) + int'(bus.regwe) + int'(bus.mulstart)) > 1) viol_cnt++;
        if (bus.regwe) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_latency", 32'(cyc - fetch_cyc + 1), 32'(e[14:7]));
                check("wb_aluctl", 32'(bus.aluctl), 32'(e[6:3]));
                check("wb_ifuresctl", 32'(bus.ifuresctl), 32'(e[0]));
                if (e[0]) check("wb_mulctl", 32'(bus.mulctl), 32'(e[2:1]));
                check("wb_pcnextctl", 32'(bus.pcnextctl), 32'd1);
                check("wb_pcmuxctl", 32'(bus.pcmuxctl), 32'd0);
            end
        end
    end

    function automatic logic [3:0] ref_alu(input logic [1:0] f7b, input logic [2:0] f3);
        logic [3:0] tab [8];
        tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (f7b == 2'b10) return (f3 == 3'b000) ? 4'd1 : 4'd7;
        return tab[f3];
    endfunction

    function automatic logic [31:0] all_outs();
        return {14'd0, bus.instrre, bus.regre, bus.regwe, bus.pcnextctl, bus.mulstart,
                bus.busy, bus.trap, bus.trap_cause, bus.aluctl, bus.mulctl,
                bus.ifuresctl, bus.pcmuxctl};
    endfunction

    task automatic reset_dut();
        rst_n        = 1'b0;
        bus.run      = 1'b0;
        bus.exdone   = 1'b0;
        bus.opcode   = 7'd0;
        bus.func3    = 3'd0;
        bus.func7b50 = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_outs", all_outs(), 32'd0);
        check("rst_instret", bus.instret, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        n_ret = 0;
    endtask

    // Issue one instruction. k=0: ALU/illegal; k>0: exdone k cycles after
    // mulstart (also held high, stale, on the mulstart cycle); k<0: never.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] f7b,
                             input int k, input bit drop_run, output int waited);
        bit seen;
        waited       = 0;
        bus.opcode   = op;
        bus.func3    = f3;
        bus.func7b50 = f7b;
        bus.run      = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.instrre;
        end
        if (!seen) begin
            check("fetch_timeout", 32'd0, 32'd1);
            return;
        end
        if (k != 0) begin
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                seen = bus.mulstart;
            end
            if (!seen) begin
                check("mulstart_timeout", 32'd0, 32'd1);
                return;
            end
            if (drop_run) bus.run = 1'b0;
            if (k > 0) begin
                bus.exdone = 1'b1;
                for (int j = 1; j <= k; j++) begin
                    @(negedge clk);
                    bus.exdone = (j == k);
                end
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            waited++;
            seen = bus.regwe | bus.trap;
        end
        bus.exdone = 1'b0;
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_alu(input logic [1:0] f7b, input logic [2:0] f3);
        int w;
        exp_q.push_back({8'd4, ref_alu(f7b, f3), 2'b00, 1'b0});
        run_instr(7'b0110011, f3, f7b, 0, 1'b0, w);
        n_ret++;
    endtask

    task automatic do_mu(input logic [1:0] mop, input int k, input bit drop_run);
        int w;
        int ms0;
        ms0 = mulstart_cnt;
        exp_q.push_back({8'(4 + k), 4'd0, mop, 1'b1});
        run_instr(7'b0110011, {1'b0, mop}, 2'b01, k, drop_run, w);
        n_ret++;
        check("mulstart_pulses", 32'(mulstart_cnt - ms0), 32'd1);
    endtask

    task automatic do_illegal(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] f7b);
        int w;
        run_instr(op, f3, f7b, 0, 1'b0, w);
        check("ill_trap", 32'(bus.trap), 32'd1);
        check("ill_cause", 32'(bus.trap_cause), 32'd1);
        repeat (4) @(negedge clk);
        check("ill_hold", {28'd0, bus.trap, bus.busy, bus.trap_cause}, 32'b1001);
        check("ill_state", 32'(dbg_state), 32'd5);
    endtask

    initial begin
        int w;
        int idx;
        bit seen;
        reset_dut();

        // Basic ALU ops
        do_alu(2'b00, 3'b000);
        check("add_instret", bus.instret, 32'(n_ret));
        do_alu(2'b10, 3'b000);
        do_alu(2'b10, 3'b101);
        for (int i = 0; i < 8; i++) begin
            idx = $urandom_range(0, 9);
            if (idx < 8) do_alu(2'b00, 3'(idx));
            else do_alu(2'b10, (idx == 8) ? 3'b000 : 3'b101);
        end
        check("alu_instret", bus.instret, 32'(n_ret));

        // Multiplies
        do_mu(2'b11, 3, 1'b0);
        for (int i = 0; i < 4; i++) do_mu(2'($urandom_range(0, 3)), $urandom_range(1, 6), 1'b0);

        // run dropped mid-EXEC: instruction finishes, then IDLE
        do_mu(2'b00, 2, 1'b1);
        repeat (3) @(negedge clk);
        check("drop_busy", 32'(bus.busy), 32'd0);
        check("drop_state", 32'(dbg_state), 32'd0);
        check("drop_instret", bus.instret, 32'(n_ret));

        // MU timeout
        run_instr(7'b0110011, 3'b000, 2'b01, -1, 1'b0, w);
        check("to_cycles", 32'(w), 32'd8);
        check("to_trap", 32'(bus.trap), 32'd1);
        check("to_cause", 32'(bus.trap_cause), 32'd2);
        repeat (5) @(negedge clk);
        check("to_hold", {28'd0, bus.trap, bus.busy, bus.trap_cause}, 32'b1010);
        check("to_instret", bus.instret, 32'(n_ret));

        // Illegal instructions
        reset_dut();
        do_illegal(7'b0010011, 3'b000, 2'b00);
        reset_dut();
        do_illegal(7'b0110011, 3'b100, 2'b01);
        reset_dut();
        do_illegal(7'b0110011, 3'($urandom_range(0, 7)), 2'b11);

        // Reset in the middle of a multiply wait
        reset_dut();
        do_alu(2'b00, 3'b100);
        bus.func3    = 3'b000;
        bus.func7b50 = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mulstart;
        end
        check("abort_mulstart_seen", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        bus.run = 1'b0;
        #1;
        check("abort_outs", all_outs(), 32'd0);
        check("abort_instret", bus.instret, 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_ret = 0;
        do_alu(2'b00, 3'b111);
        check("recover_instret", bus.instret, 32'd1);

        repeat (2) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("exclusive_enables", 32'(viol_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
